// File: rtl/router_psum_load_pkg.sv
// ============================================================================
// router_psum_load_pkg: state encodings and width helper shared by psum routers
// Revision: 1.0
// ============================================================================
`default_nettype none

package router_psum_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } psum_state_e;

  // Counter width for a range of `value` entries, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_psum_load.sv
// ============================================================================
// router_psum_load: reads Y_dim groups of X_dim psum words from the GLB and
// presents each group as one packed lane vector with a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_psum_load
  import router_psum_load_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int Y_dim             = 3,
  parameter int PSUM_LOAD_ADDR    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_psum_ctrl,
  output logic                             read_en_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0]     r_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]         r_data_glb_psum,
  output logic [DATA_BITWIDTH*X_dim-1:0]   south_data_o,
  output logic                             south_enable_o,
  input  logic                             south_ready_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int WCW = clog2_min1(X_dim);
  localparam int GCW = clog2_min1(Y_dim);
  localparam logic [WCW-1:0] W_LAST = WCW'(X_dim - 1);
  localparam logic [GCW-1:0] G_LAST = GCW'(Y_dim - 1);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_ADDR = ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] STRIDE    = ADDR_BITWIDTH_GLB'(X_dim);

  psum_state_e                        state_q, state_d;
  logic [WCW-1:0]                     word_cnt_q, word_cnt_d;
  logic [GCW-1:0]                     group_cnt_q, group_cnt_d;
  logic                               cap_en_q;
  logic [WCW-1:0]                     cap_idx_q;
  logic [DATA_BITWIDTH*X_dim-1:0]     lane_q;
  logic [ADDR_BITWIDTH_GLB-1:0]       addr_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load_psum_ctrl) state_d = ST_READ;
      ST_READ:    if (word_cnt_q == W_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_PRESENT;
      ST_PRESENT: if (south_ready_i) state_d = (group_cnt_q == G_LAST) ? ST_DONE : ST_READ;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_cnt_d  = word_cnt_q;
    group_cnt_d = group_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load_psum_ctrl) begin
          word_cnt_d  = '0;
          group_cnt_d = '0;
        end
      end
      ST_READ: word_cnt_d = word_cnt_q + 1'b1;
      ST_PRESENT: begin
        if (south_ready_i && (group_cnt_q != G_LAST)) begin
          group_cnt_d = group_cnt_q + 1'b1;
          word_cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // GLB data arrives one cycle after the strobe, so the lane index is delayed to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q  <= '0;
      group_cnt_q <= '0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
      lane_q      <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      group_cnt_q <= group_cnt_d;
      cap_en_q    <= (state_q == ST_READ);
      cap_idx_q   <= word_cnt_q;
      for (int i = 0; i < X_dim; i++) begin
        if (cap_en_q && (cap_idx_q == WCW'(i))) begin
          lane_q[i*DATA_BITWIDTH +: DATA_BITWIDTH] <= r_data_glb_psum;
        end
      end
    end
  end

  // Modular arithmetic at the address width gives the required wrap-around.
  assign addr_w = BASE_ADDR + ADDR_BITWIDTH_GLB'(group_cnt_q) * STRIDE
                + ADDR_BITWIDTH_GLB'(word_cnt_q);

  always_comb begin
    read_en_glb_psum = (state_q == ST_READ);
    r_addr_glb_psum  = read_en_glb_psum ? addr_w : '0;
    south_enable_o   = (state_q == ST_PRESENT);
    south_data_o     = south_enable_o ? lane_q : '0;
    busy_o           = (state_q != ST_IDLE);
    done_o           = (state_q == ST_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_router_psum_load.sv
// ============================================================================
// tb_router_psum_load: two instances (base 0x020 and wrapping base 0x3FC)
// checked cycle by cycle against a schedule-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_router_psum_load;

  localparam int XD = 5;
  localparam int YD = 3;
  localparam int BASE_A = 32'h20;
  localparam int BASE_B = 32'h3FC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        rdy = 1'b0;
  logic        rd_a, rd_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] rdata_a = '0, rdata_b = '0;
  logic [79:0] data_a, data_b;
  logic [15:0] mem [1024];

  int vectors = 0;
  int miscompares = 0;

  logic        tr_rd   [64];
  logic [9:0]  tr_addr [64];
  logic        tr_en   [64];
  logic        tr_done [64];
  logic [79:0] tr_vec  [64];

  typedef struct {
    int         cyc;
    logic       rd;
    logic [9:0] addr;
    logic       en;
    logic [15:0] lane0;
    logic [15:0] lane4;
    logic       done;
  } chk_t;
  chk_t tbl [10];

  always #5 clk = ~clk;

  router_psum_load #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10), .X_dim(XD), .Y_dim(YD),
                     .PSUM_LOAD_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset(reset), .load_psum_ctrl(load), .read_en_glb_psum(rd_a),
    .r_addr_glb_psum(addr_a), .r_data_glb_psum(rdata_a), .south_data_o(data_a),
    .south_enable_o(en_a), .south_ready_i(rdy), .busy_o(busy_a), .done_o(done_a));

  router_psum_load #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH_GLB(10), .X_dim(XD), .Y_dim(YD),
                     .PSUM_LOAD_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .load_psum_ctrl(load), .read_en_glb_psum(rd_b),
    .r_addr_glb_psum(addr_b), .r_data_glb_psum(rdata_b), .south_data_o(data_b),
    .south_enable_o(en_b), .south_ready_i(rdy), .busy_o(busy_b), .done_o(done_b));

  // GLB model: one-cycle read latency, garbage on the bus when not strobed.
  always @(posedge clk) begin
    rdata_a <= rd_a ? mem[addr_a] : 16'($urandom);
    rdata_b <= rd_b ? mem[addr_b] : 16'($urandom);
  end

  function automatic logic [127:0] pk(input logic rd, input logic [9:0] ad, input logic en,
                                      input logic bz, input logic dn, input logic [79:0] d);
    return {34'd0, rd, ad, en, bz, dn, d};
  endfunction

  function automatic logic [9:0] word_addr(input int base, input int g, input int w);
    return 10'((base + g * XD + w) % 1024);
  endfunction

  function automatic logic [79:0] exp_vec(input int base, input int g);
    logic [79:0] v;
    for (int i = 0; i < XD; i++) v[i*16 +: 16] = mem[word_addr(base, g, i)];
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_a"}, pk(rd_a, addr_a, en_a, busy_a, done_a, data_a), 128'd0);
    check({name, "_b"}, pk(rd_b, addr_b, en_b, busy_b, done_b, data_b), 128'd0);
  endtask

  // Pulses start, then checks every cycle until the done pulse. Expected
  // timing: group g reads in cycles s..s+XD-1, presents from s+XD+1 until
  // accepted at cycle c, next group starts at c+1; done one cycle after the
  // last acceptance. Returns in the done cycle, #1 after its edge.
  task automatic run_seq(input int stall_pct, input bit repulse, input int stall_first);
    int g, s, done_n, pres_cnt, n;
    logic e_rd, e_en, e_dn;
    logic [9:0] ea, eb;
    logic [79:0] va, vb;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    g = 0; s = 1; done_n = -1; pres_cnt = 0;
    for (n = 1; n < 400; n++) begin
      e_rd = 0; e_en = 0; e_dn = 0; ea = '0; eb = '0; va = '0; vb = '0;
      if (n == done_n) begin
        e_dn = 1;
      end else if (n >= s && n < s + XD) begin
        e_rd = 1;
        ea = word_addr(BASE_A, g, n - s);
        eb = word_addr(BASE_B, g, n - s);
      end else if (n >= s + XD + 1) begin
        e_en = 1;
        va = exp_vec(BASE_A, g);
        vb = exp_vec(BASE_B, g);
      end
      check("cycle_a", pk(rd_a, addr_a, en_a, busy_a, done_a, data_a), pk(e_rd, ea, e_en, 1'b1, e_dn, va));
      check("cycle_b", pk(rd_b, addr_b, en_b, busy_b, done_b, data_b), pk(e_rd, eb, e_en, 1'b1, e_dn, vb));
      if (n < 64) begin
        tr_rd[n] = rd_a; tr_addr[n] = addr_a; tr_en[n] = en_a; tr_done[n] = done_a; tr_vec[n] = data_a;
      end
      if (n == done_n) break;
      if (e_en) begin
        if (g == 0 && pres_cnt < stall_first) rdy = 1'b0;
        else if (stall_pct > 0) rdy = ($urandom_range(99) >= stall_pct);
        else rdy = 1'b1;
        if (g == 0) pres_cnt++;
        if (rdy) begin
          if (g == YD - 1) done_n = n + 1;
          else begin g++; s = n + 1; end
        end
      end else begin
        rdy = 1'($urandom_range(1));
      end
      load = repulse && (e_rd || e_en) && ($urandom_range(1) == 1);
      @(posedge clk); #1;
    end
    load = 1'b0;
    rdy = 1'b1;
    if (done_n < 0 || n >= 400) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no done pulse within 400 cycles (got none, required one)");
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
    tbl[0] = '{1,  1'b1, 10'h020, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{5,  1'b1, 10'h024, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{6,  1'b0, 10'h000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{7,  1'b0, 10'h000, 1'b1, 16'h0020, 16'h0024, 1'b0};
    tbl[4] = '{8,  1'b1, 10'h025, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{14, 1'b0, 10'h000, 1'b1, 16'h0025, 16'h0029, 1'b0};
    tbl[6] = '{15, 1'b1, 10'h02A, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[7] = '{19, 1'b1, 10'h02E, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[8] = '{21, 1'b0, 10'h000, 1'b1, 16'h002A, 16'h002E, 1'b0};
    tbl[9] = '{22, 1'b0, 10'h000, 1'b0, 16'h0000, 16'h0000, 1'b1};

    // Reset state, with start asserted to show it is ignored under reset.
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle("reset_state");
    load = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    // Directed run: ready always high, checked per cycle and at table checkpoints.
    run_seq(0, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tbl_cyc%0d", tbl[k].cyc),
            {tr_rd[tbl[k].cyc], tr_addr[tbl[k].cyc], tr_en[tbl[k].cyc], tr_done[tbl[k].cyc],
             tr_vec[tbl[k].cyc][15:0], tr_vec[tbl[k].cyc][79:64]},
            {tbl[k].rd, tbl[k].addr, tbl[k].en, tbl[k].done, tbl[k].lane0, tbl[k].lane4});
    end

    // Back-to-back: exactly one idle cycle between sequences.
    @(posedge clk); #1;
    check_idle("b2b_gap");
    run_seq(0, 1'b0, 4);

    // Start re-pulsed while busy must be ignored.
    @(posedge clk); #1;
    check_idle("pre_repulse");
    run_seq(0, 1'b1, 0);
    @(posedge clk); #1;
    check_idle("after_repulse");

    // Asynchronous reset in the middle of group 1 reads.
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_read_a", pk(rd_a, addr_a, en_a, busy_a, done_a, data_a),
          pk(1'b1, 10'h027, 1'b0, 1'b1, 1'b0, 80'd0));
    #3 reset = 1'b0;
    #1 check_idle("async_reset");
    @(posedge clk); #2;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_idle("after_abort");
    end
    run_seq(0, 1'b0, 0);

    // Randomized runs over random memory contents and ready stalls.
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
      repeat ($urandom_range(3) + 1) begin
        @(posedge clk); #1;
        check_idle("rand_idle");
      end
      run_seq(int'($urandom_range(70)), 1'b1, int'($urandom_range(3)));
    end

    @(posedge clk); #1;
    check_idle("final_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
